// File: rtl/debouncer.sv
// debouncer: tick-sampled debouncer that changes level after PULSE_CNT_MAX consecutive disagreeing ticks.
// Edge pulses are built only when DEBOUNCER_EDGE_EN is defined; otherwise they are tied low.
module debouncer #(
  parameter int   SAMPLE_CNT_MAX = 25000,
  parameter int   PULSE_CNT_MAX  = 200,
  parameter logic RESET_VALUE    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic debounced_out,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam int SW = $clog2(SAMPLE_CNT_MAX) + 1;
  localparam int AW = $clog2(PULSE_CNT_MAX) + 1;
  logic [SW-1:0] smp_q, smp_d;
  logic [AW-1:0] agr_q, agr_d;
  logic deb_q, deb_d, tick, hit;
  always_comb begin
    tick  = smp_q == SW'(SAMPLE_CNT_MAX - 1);
    smp_d = tick ? '0 : smp_q + 1'b1;
    hit   = (agr_q + 1'b1) == AW'(PULSE_CNT_MAX);
    agr_d = !tick ? agr_q : (sync_in == deb_q || hit) ? '0 : agr_q + 1'b1;
    deb_d = (tick && sync_in != deb_q && hit) ? sync_in : deb_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      smp_q <= '0;
      agr_q <= '0;
      deb_q <= RESET_VALUE;
    end else begin
      smp_q <= smp_d;
      agr_q <= agr_d;
      deb_q <= deb_d;
    end
  end
  assign debounced_out = deb_q;
`ifdef DEBOUNCER_EDGE_EN
  // prev_q reloads RESET_VALUE with deb_q so the reset load never looks like an edge
  logic prev_q, rise_q, fall_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= RESET_VALUE;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= deb_q;
      rise_q <= deb_q & ~prev_q;
      fall_q <= ~deb_q & prev_q;
    end
  end
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif
endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 The module SHALL provide parameter SAMPLE_CNT_MAX, default 25000, meaning clk cycles per sample tick (legal range >= 1).
REQ-002 The module SHALL provide parameter PULSE_CNT_MAX, default 200, meaning consecutive disagreeing ticks required to change state (legal range >= 1).
REQ-003 The module SHALL provide parameter RESET_VALUE, default 1'b0, meaning debounced level after reset.
REQ-004 The module SHALL provide port clk, input, 1 bit, the single clock for all state.
REQ-005 The module SHALL provide port reset, input, 1 bit, synchronous active-high reset.
REQ-006 The module SHALL provide port sync_in, input, 1 bit, level already synchronized into the clk domain by the upstream sync stage.
REQ-007 The module SHALL provide port debounced_out, output, 1 bit, registered debounced level.
REQ-008 The module SHALL provide port rise_pulse, output, 1 bit, one-cycle pulse on debounced 0->1.
REQ-009 The module SHALL provide port fall_pulse, output, 1 bit, one-cycle pulse on debounced 1->0.

Function
REQ-010 The sample counter SHALL be $clog2(SAMPLE_CNT_MAX)+1 bits wide, count 0..SAMPLE_CNT_MAX-1 and wrap to 0.
REQ-011 A tick SHALL be asserted internally in each cycle where the sample counter equals SAMPLE_CNT_MAX-1; with SAMPLE_CNT_MAX=1 a tick SHALL occur every cycle.
REQ-012 The agree counter SHALL be $clog2(PULSE_CNT_MAX)+1 bits wide and SHALL never exceed PULSE_CNT_MAX.
REQ-013 On a tick with sync_in != debounced_out, the agree counter SHALL increment by 1.
REQ-014 On a tick with sync_in == debounced_out, the agree counter SHALL clear to 0.
REQ-015 When an increment would make the agree counter equal PULSE_CNT_MAX, debounced_out SHALL take the value of sync_in on the next clock edge, and the agree counter SHALL clear to 0 on that same edge.
REQ-016 On non-tick cycles, debounced_out and the agree counter SHALL hold their values, regardless of sync_in.
REQ-017 Minimum latency from a stable input change to the debounced_out change SHALL be PULSE_CNT_MAX ticks; debounced_out SHALL update on the edge ending the PULSE_CNT_MAX-th consecutive disagreeing tick.
REQ-018 rise_pulse SHALL be high for exactly the one cycle after debounced_out transitions 0->1; fall_pulse SHALL likewise be high for one cycle after a 1->0 transition.
REQ-019 rise_pulse and fall_pulse SHALL never be high in the same cycle.
REQ-020 A single disagreeing tick followed by an agreeing tick SHALL discard all accumulated count; there is no partial credit.

Reset
REQ-021 While reset is high at a clock edge, the sample counter and agree counter SHALL clear to 0, and debounced_out SHALL load RESET_VALUE.
REQ-022 While reset is high at a clock edge, rise_pulse and fall_pulse SHALL clear to 0.
REQ-023 Reset asserted mid-count SHALL abandon any pending transition; no edge pulse SHALL result from the reset load of debounced_out.
REQ-024 After reset deasserts, the first tick SHALL occur SAMPLE_CNT_MAX cycles later.

Configuration
REQ-025 Macro DEBOUNCER_EDGE_EN SHALL control the edge-pulse logic; when defined, rise_pulse and fall_pulse SHALL behave per REQ-018/019.
REQ-026 When DEBOUNCER_EDGE_EN is undefined, rise_pulse and fall_pulse SHALL be constant 0, no edge registers SHALL be synthesized, and the port list SHALL be unchanged.

Verification (SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, RESET_VALUE=0, DEBOUNCER_EDGE_EN defined unless stated)
REQ-027 The bench SHALL cover the rise case: reset released at cycle 0, sync_in=1 from cycle 0 -> ticks at cycles 3, 7, 11; debounced_out=1 from cycle 12; rise_pulse=1 in cycle 13 only.
REQ-028 The bench SHALL cover the glitch case: sync_in=1 for cycles 0..8 then 0 -> ticks 3 and 7 disagree, tick 11 agrees; debounced_out stays 0 and no pulses occur.
REQ-029 The bench SHALL cover the fall case: from debounced_out=1, sync_in=0 held for 3 ticks -> debounced_out=0 after the 3rd tick; fall_pulse=1 for one cycle; rise_pulse stays 0.
REQ-030 The bench SHALL cover reset mid-count: 2 disagreeing ticks, then reset for 1 cycle, with sync_in still 1 -> debounced_out=0; 3 further ticks are needed, and the first of them falls 4 cycles after reset deasserts.
REQ-031 The bench SHALL cover RESET_VALUE=1 with sync_in=1 -> debounced_out=1 immediately after reset, and no rise_pulse occurs.
REQ-032 The bench SHALL cover the macro-off build: with DEBOUNCER_EDGE_EN undefined, rerun REQ-027 -> debounced_out timing is identical and rise_pulse/fall_pulse stay 0 throughout.
